// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: control from the pipeline, the ROM address/data pair and the decode-side result.
// The master modport is the fetch unit; the slave modport is the pipeline plus the ROM around it.
interface instr_fetch_if #(
  parameter int ADDR_W = 10
);
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halt_req;
  logic              resume;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_dout;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              if_valid;
  logic              halted;

  modport master (
    input  stall, redirect, redirect_pc, halt_req, resume, rom_dout,
    output rom_addr, if_pc, if_instr, if_valid, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, halt_req, resume, rom_dout,
    input  rom_addr, if_pc, if_instr, if_valid, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: PC drives the ROM word address, the ROM word lands in IR one edge later.
// stall holds PC/IR/if_valid; redirect and halt_req squash. FETCH_PERF_EN adds a fetch counter port.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  instr_fetch_if.master     bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] ir_q, ir_nxt;
  logic [31:0] ifpc_q, ifpc_nxt;
  logic        vld_q, vld_nxt;
  logic        fetch;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      ifpc_q  <= 32'h0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
      ifpc_q  <= ifpc_nxt;
      vld_q   <= vld_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    ir_nxt    = ir_q;
    ifpc_nxt  = ifpc_q;
    vld_nxt   = vld_q;
    fetch     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.redirect) begin
          // Squash but keep IR/if_pc so decode still sees the last real instruction.
          pc_nxt  = redirect_tgt;
          vld_nxt = 1'b0;
          if (bus.halt_req) state_nxt = HALT;
        end else if (bus.halt_req) begin
          state_nxt = HALT;
          vld_nxt   = 1'b0;
        end else if (!bus.stall) begin
          ir_nxt   = bus.rom_dout;
          ifpc_nxt = pc_q;
          vld_nxt  = 1'b1;
          pc_nxt   = pc_q + 32'd4;
          fetch    = 1'b1;
        end
      end
      HALT: begin
        vld_nxt = 1'b0;
        if (bus.redirect) pc_nxt = redirect_tgt;
        if (bus.resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign bus.rom_addr = pc_q[ADDR_W+1:2];
  assign bus.if_pc    = ifpc_q;
  assign bus.if_instr = ir_q;
  assign bus.if_valid = vld_q;
  assign bus.halted   = (state_q == HALT);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_fetch_cnt <= 32'h0;
    else if (fetch) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
  end
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

endmodule
